// File: rtl/rr_sched_pkg.sv
// Shared definitions for the round-robin lock scheduler: FSM state encoding,
// a constant clog2 helper and the default hold limit.
package rr_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int MAX_HOLD_DEFAULT = 16;

    // Ceiling log2, usable in parameter defaults.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_lock_scheduler_if.sv
// Request/grant bundle between requesting masters and the lock scheduler.
//
// Handshake: a master raises req[i] and holds it until it has been served.
// The scheduler answers with a registered one-hot gnt; gnt_valid is |gnt and
// gnt_id is the index of the held grant (it keeps its last value while
// gnt_valid is low). The master owns the resource for every cycle gnt[i] is
// high and ends its tenure by pulsing done[i] or by dropping req[i]; either
// is seen at the next rising edge and is followed by one idle gap cycle.
interface rr_lock_scheduler_if
    import rr_sched_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = clog2(N)
);
    logic [N-1:0]   req;
    logic [N-1:0]   done;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           timeout;

    modport master (
        output req, done,
        input  gnt, gnt_valid, gnt_id, busy, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_valid, gnt_id, busy, timeout
    );
endinterface

// File: rtl/rr_pick.sv
// Rotating-priority picker: returns the first asserted request when scanning
// from ptr upward, wrapping at N. Purely combinational, reusable by other
// round-robin arbiters.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] winner,
    output logic           any
);

    logic [IDW:0] idx;

    // Walk the N positions in priority order and latch the first hit.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + (IDW + 1)'(k);
            if (idx >= (IDW + 1)'(N)) begin
                idx = idx - (IDW + 1)'(N);
            end
            if (!any && req[idx[IDW-1:0]]) begin
                any    = 1'b1;
                winner = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/rr_lock_scheduler.sv
// N-requester round-robin scheduler for one shared resource. A winner keeps
// the grant until it pulses done or drops req; each release is followed by a
// single gap cycle, and the priority pointer moves past every new winner.
// Optional hold limit: define RR_HOLD_TIMEOUT_EN to force a release after
// MAX_HOLD grant cycles and flag it on timeout.
module rr_lock_scheduler
    import rr_sched_pkg::*;
#(
    parameter int N        = 4,
    parameter int IDW      = clog2(N),
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_lock_scheduler_if.slave   bus,
    output state_t               dbg_state,
    output logic [IDW-1:0]       dbg_ptr
);

    // Reject configurations outside the supported range at elaboration.
    if (N < 2 || N > 16 || MAX_HOLD < 2) begin : g_cfg_check
        $error("rr_lock_scheduler: unsupported N or MAX_HOLD");
    end

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;

    logic [IDW-1:0] pick_id;
    logic           pick_any;
    logic           release_now;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .winner (pick_id),
        .any    (pick_any)
    );

    // A done or a dropped request from the holder ends the tenure; both in
    // the same cycle are still one release.
    assign release_now = bus.done[id_q] | ~bus.req[id_q];

`ifdef RR_HOLD_TIMEOUT_EN
    localparam int HOLD_W = clog2(MAX_HOLD);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              tmo_q, tmo_d;
    logic              hold_limit;

    assign hold_limit = (hold_q == HOLD_W'(MAX_HOLD - 1));
`endif

    // Next-state, pointer, grant and hold-count decisions.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        gnt_d   = gnt_q;
`ifdef RR_HOLD_TIMEOUT_EN
        hold_d  = hold_q;
        tmo_d   = 1'b0;
`endif
        case (state_q)
            IDLE, GAP: begin
                if (pick_any) begin
                    state_d        = GRANT;
                    gnt_d          = '0;
                    gnt_d[pick_id] = 1'b1;
                    id_d           = pick_id;
                    ptr_d          = (pick_id == IDW'(N - 1)) ? '0 : pick_id + IDW'(1);
`ifdef RR_HOLD_TIMEOUT_EN
                    hold_d         = '0;
`endif
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d = GAP;
                    gnt_d   = '0;
`ifdef RR_HOLD_TIMEOUT_EN
                end else if (hold_limit) begin
                    state_d = GAP;
                    gnt_d   = '0;
                    tmo_d   = 1'b1;
                end else begin
                    hold_d  = hold_q + HOLD_W'(1);
`endif
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
        valid_d = |gnt_d;
        busy_d  = (state_d != IDLE);
    end

    // State and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

`ifdef RR_HOLD_TIMEOUT_EN
    // Hold counter and the one-cycle forced-release pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            hold_q <= hold_d;
            tmo_q  <= tmo_d;
        end
    end

    assign bus.timeout = tmo_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = valid_q;
    assign bus.gnt_id    = id_q;
    assign bus.busy      = busy_q;
    assign dbg_state     = state_q;
    assign dbg_ptr       = ptr_q;

endmodule

// File: tb/tb_rr_lock_scheduler.sv
// Bench for rr_lock_scheduler: directed scenarios with literal expectations,
// then randomized request/done traffic with occasional asynchronous resets,
// all checked every cycle against a behavioural owner/gap/pointer model.
module tb_rr_lock_scheduler;
    import rr_sched_pkg::*;

    localparam int N        = 4;
    localparam int IDW      = 2;
    localparam int MAX_HOLD = 4;

    logic           clk;
    logic           rst;
    state_t         dbg_state;
    logic [IDW-1:0] dbg_ptr;

    rr_lock_scheduler_if #(.N(N), .IDW(IDW)) bus ();

    rr_lock_scheduler #(
        .N        (N),
        .IDW      (IDW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state),
        .dbg_ptr   (dbg_ptr)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [IDW-1:0] exp_q[$];

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // owner: requester holding the resource (-1 none); gap: in the idle
    // cycle after a release; ptr: first requester to look at next time.
    int m_owner = -1;
    bit m_gap   = 1'b0;
    int m_ptr   = 0;
    int m_last  = 0;
    int m_held  = 0;
    bit m_tmo   = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_owner = -1;
            m_gap   = 1'b0;
            m_ptr   = 0;
            m_last  = 0;
            m_held  = 0;
            m_tmo   = 1'b0;
        end else begin
            m_tmo = 1'b0;
            if (m_owner >= 0) begin
                m_held = m_held + 1;
                if (!bus.req[m_owner] || bus.done[m_owner]) begin
                    m_owner = -1;
                    m_gap   = 1'b1;
                end
`ifdef RR_HOLD_TIMEOUT_EN
                else if (m_held >= MAX_HOLD) begin
                    m_owner = -1;
                    m_gap   = 1'b1;
                    m_tmo   = 1'b1;
                end
`endif
            end else begin
                m_gap = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && bus.req[(m_ptr + k) % N]) begin
                        m_owner = (m_ptr + k) % N;
                    end
                end
                if (m_owner >= 0) begin
                    m_last = m_owner;
                    m_ptr  = (m_owner + 1) % N;
                    m_held = 0;
                end
            end
        end
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        logic [N-1:0] e_gnt;
        state_t       e_state;
        e_gnt = '0;
        if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
        e_state = (m_owner >= 0) ? GRANT : (m_gap ? GAP : IDLE);
        check("gnt",       32'(bus.gnt),       32'(e_gnt));
        check("gnt_valid", 32'(bus.gnt_valid), 32'(m_owner >= 0));
        check("gnt_id",    32'(bus.gnt_id),    32'(m_last));
        check("busy",      32'(bus.busy),      32'((m_owner >= 0) || m_gap));
        check("timeout",   32'(bus.timeout),   32'(m_tmo));
        check("ptr",       32'(dbg_ptr),       32'(m_ptr));
        check("state",     32'(dbg_state),     32'(e_state));
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        bus.req  = '0;
        bus.done = '0;
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_grant(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            if (bus.gnt_valid) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_grant: no grant within %0d cycles", budget);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        int held;
        rst      = 1'b0;
        bus.req  = '0;
        bus.done = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt",   32'(bus.gnt),    32'h0);
        check("rst_id",    32'(bus.gnt_id), 32'h0);
        check("rst_busy",  32'(bus.busy),   32'h0);
        check("rst_ptr",   32'(dbg_ptr),    32'h0);
        rst = 1'b1;

        // Single requester, done after four grant cycles.
        @(negedge clk);
        bus.req = 4'b0100;
        @(negedge clk);
        check("single_gnt", 32'(bus.gnt),    32'h4);
        check("single_id",  32'(bus.gnt_id), 32'h2);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("single_hold", 32'(bus.gnt), 32'h4);
        bus.done = 4'b0100;
        @(negedge clk);
        bus.done = '0;
        bus.req  = '0;
        check("single_gap_gnt",  32'(bus.gnt),     32'h0);
        check("single_gap_busy", 32'(bus.busy),    32'h1);
        check("single_gap_tmo",  32'(bus.timeout), 32'h0);
        @(negedge clk);
        check("single_idle_busy", 32'(bus.busy),   32'h0);
        check("single_idle_id",   32'(bus.gnt_id), 32'h2);

        // Everybody requesting, each holder finishing after one cycle.
        apply_reset();
        for (int k = 0; k < 5; k++) exp_q.push_back(IDW'(k % N));
        bus.req  = 4'b1111;
        bus.done = 4'b1111;
        while (exp_q.size() > 0) begin
            logic [IDW-1:0] e;
            e = exp_q.pop_front();
            wait_grant(4, ok);
            check("order_id", 32'(bus.gnt_id), 32'(e));
            @(negedge clk);
            check("order_gap", 32'(bus.gnt_valid), 32'h0);
        end

        // Fairness: 1011 held; after 1 releases, 3 beats 0.
        apply_reset();
        bus.req = 4'b1011;
        @(negedge clk);
        check("fair_first", 32'(bus.gnt_id), 32'h0);
        bus.done = 4'b0001;
        @(negedge clk);
        bus.done = '0;
        @(negedge clk);
        check("fair_second", 32'(bus.gnt_id), 32'h1);
        check("fair_ptr",    32'(dbg_ptr),    32'h2);
        bus.done = 4'b0010;
        @(negedge clk);
        bus.done = '0;
        @(negedge clk);
        check("fair_third", 32'(bus.gnt_id), 32'h3);

        // Release 3, then a spurious done[3] while 0 holds, then 0 abandons.
        bus.done = 4'b1000;
        @(negedge clk);
        bus.done = '0;
        @(negedge clk);
        check("abandon_grant0", 32'(bus.gnt), 32'h1);
        bus.done = 4'b1000;
        @(negedge clk);
        check("spurious_done", 32'(bus.gnt), 32'h1);
        bus.done = '0;
        bus.req  = 4'b1010;
        @(negedge clk);
        check("abandon_gap",  32'(bus.gnt),  32'h0);
        check("abandon_busy", 32'(bus.busy), 32'h1);
        @(negedge clk);
        check("abandon_next", 32'(bus.gnt), 32'h2);

        // Reset while requester 1 holds the grant.
        bus.req = 4'b0110;
        #2 rst = 1'b0;
        #1;
        check("rstmid_gnt",   32'(bus.gnt),       32'h0);
        check("rstmid_valid", 32'(bus.gnt_valid), 32'h0);
        check("rstmid_busy",  32'(bus.busy),      32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_regrant", 32'(bus.gnt),    32'h2);
        check("rstmid_id",      32'(bus.gnt_id), 32'h1);

`ifdef RR_HOLD_TIMEOUT_EN
        // Holder never finishes: forced release after MAX_HOLD cycles.
        apply_reset();
        bus.req = 4'b0011;
        held = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.gnt == 4'b0001) held++;
            else if (held > 0) break;
        end
        check("tmo_hold_cycles", 32'(held),         32'(MAX_HOLD));
        check("tmo_pulse",       32'(bus.timeout),  32'h1);
        check("tmo_gap_busy",    32'(bus.busy),     32'h1);
        @(negedge clk);
        check("tmo_next_id",     32'(bus.gnt_id),   32'h1);
        check("tmo_pulse_end",   32'(bus.timeout),  32'h0);
`else
        held = 0;
`endif

        // Randomized traffic with sparse asynchronous resets.
        apply_reset();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!bus.req[i]) bus.req[i] = ($urandom_range(0, 9) < 3);
                else             bus.req[i] = ($urandom_range(0, 9) != 0);
                bus.done[i] = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
        end
        bus.req  = '0;
        bus.done = '0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
